// File: rtl/register_file.sv
// register_file: 32 x N_BITS MIPS general-purpose register file.
// Two asynchronous read ports (rs -> ALU A, rt -> ALU B / store data) and one
// synchronous write port fed from the write-back path. $zero has no storage
// and always reads 0. $gp (28) and $sp (29) get their initial values on reset.
//
// Optional build macro: REGFILE_BYPASS_EN
//   defined   -> a write presented this cycle is forwarded combinationally to
//                any read port addressing the same non-zero register, so
//                write-back and decode can share one cycle.
//   undefined -> read-during-write returns the old value until the edge.
//
// Interface contract: there is no handshake. A write is committed at the
// rising edge of clk whenever RegWrite=1, reset=0 and WriteRegister!=0.
// Reads have zero-cycle latency from the read index to the read data.
module register_file #(
  parameter int                N_BITS  = 32,
  parameter logic [N_BITS-1:0] SP_INIT = N_BITS'(32'h7FFF_EFFC),
  parameter logic [N_BITS-1:0] GP_INIT = N_BITS'(32'h1000_8000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [N_BITS-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [N_BITS-1:0] ReadData1,
  output logic [N_BITS-1:0] ReadData2
);

  // Read view of every architectural register; entry 0 is the constant $zero.
  logic [N_BITS-1:0] rd_arr [32];

  // $zero has no storage behind it.
  assign rd_arr[0] = '0;

  // One storage register per index 1..31, each with its own write decode so
  // no dynamic-index write into a shared array is needed.
  for (genvar k = 1; k < 32; k++) begin : g_reg
    localparam logic [4:0] IDX = 5'(k);
    localparam logic [N_BITS-1:0] RST_VAL = (k == 28) ? GP_INIT :
                                            (k == 29) ? SP_INIT : '0;

    logic [N_BITS-1:0] reg_q;
    logic [N_BITS-1:0] reg_d;
    logic              wr_hit;

    assign wr_hit = RegWrite && (WriteRegister == IDX);

    // Next-state: hold unless this index is the write target.
    always_comb begin
      reg_d = reg_q;
      if (wr_hit) begin
        reg_d = WriteData;
      end
    end

    // State register: reset has priority over a write in the same cycle.
    always_ff @(posedge clk) begin
      if (reset) begin
        reg_q <= RST_VAL;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign rd_arr[k] = reg_q;
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;
  logic wr_live;

  // A write is forwarded only when it would really commit at the next edge.
  assign wr_live = RegWrite && !reset && (WriteRegister != 5'd0);
  assign byp1    = wr_live && (WriteRegister == ReadRegister1);
  assign byp2    = wr_live && (WriteRegister == ReadRegister2);

  // Read ports with write-through forwarding.
  always_comb begin
    ReadData1 = rd_arr[ReadRegister1];
    ReadData2 = rd_arr[ReadRegister2];
    if (byp1) begin
      ReadData1 = WriteData;
    end
    if (byp2) begin
      ReadData2 = WriteData;
    end
  end
`else
  // Read ports straight from stored state.
  always_comb begin
    ReadData1 = rd_arr[ReadRegister1];
    ReadData2 = rd_arr[ReadRegister2];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: self-checking bench for register_file.
// Scenario tasks each drive stimulus and compare against a behavioural model
// (an array of 32 words updated by the architectural write/reset rules).
module tb_register_file;

  localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_VAL = 32'h1000_8000;

  // ---------------- clock / reset block ----------------
  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  register_file dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  // ---------------- reference model ----------------
  logic [31:0] model [32];
  int vectors    = 0;
  int miscompares = 0;

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    return model[idx];
  endfunction

  // Value a read port should show before the edge, given the inputs now applied.
  function automatic logic [31:0] model_read_now(input logic [4:0] idx);
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && !reset && WriteRegister != 5'd0 && WriteRegister == idx)
      return WriteData;
`endif
    return model_read(idx);
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one rising edge and commit the architectural effect into the model.
  task automatic apply_edge();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[28] = GP_VAL;
      model[29] = SP_VAL;
    end else if (RegWrite && WriteRegister != 5'd0) begin
      model[WriteRegister] = WriteData;
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
    reset = 1'b0; RegWrite = 1'b1; WriteRegister = idx; WriteData = data;
    apply_edge();
    RegWrite = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] exp;
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    apply_edge();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      exp = (i == 28) ? GP_VAL : (i == 29) ? SP_VAL : 32'h0;
      vectors++;
      if (ReadData1 !== exp) begin
        miscompares++;
        $display("FAIL reset_sweep_rd1 idx=%0d got=%h exp=%h", i, ReadData1, exp);
      end
      exp = (31 - i == 28) ? GP_VAL : (31 - i == 29) ? SP_VAL : 32'h0;
      vectors++;
      if (ReadData2 !== exp) begin
        miscompares++;
        $display("FAIL reset_sweep_rd2 idx=%0d got=%h exp=%h", 31 - i, ReadData2, exp);
      end
    end
  endtask

  task automatic test_write_read();
    write_reg(5'd8, 32'hDEAD_BEEF);
    write_reg(5'd9, 32'h0000_0005);
    ReadRegister1 = 5'd8; ReadRegister2 = 5'd9; #1;
    vectors++;
    if (ReadData1 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_read_rd1 got=%h exp=%h", ReadData1, 32'hDEAD_BEEF);
    end
    vectors++;
    if (ReadData2 !== 32'h0000_0005) begin
      miscompares++;
      $display("FAIL write_read_rd2 got=%h exp=%h", ReadData2, 32'h0000_0005);
    end
    ReadRegister2 = 5'd8; #1;
    vectors++;
    if (ReadData2 !== ReadData1 || ReadData2 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL same_index_both_ports got1=%h got2=%h exp=%h", ReadData1, ReadData2, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_zero_guard();
    write_reg(5'd0, 32'hFFFF_FFFF);
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0; #1;
    vectors++;
    if (ReadData1 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_guard_rd1 got=%h exp=%h", ReadData1, 32'h0);
    end
    vectors++;
    if (ReadData2 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_guard_rd2 got=%h exp=%h", ReadData2, 32'h0);
    end
  endtask

  task automatic test_write_disabled();
    reset = 1'b0; RegWrite = 1'b0; WriteRegister = 5'd8; WriteData = 32'h1234_5678;
    apply_edge();
    ReadRegister1 = 5'd8; #1;
    vectors++;
    if (ReadData1 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_disabled got=%h exp=%h", ReadData1, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_reset_priority();
    write_reg(5'd10, 32'h0000_0055);
    reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 32'hAAAA_AAAA;
    ReadRegister1 = 5'd10; ReadRegister2 = 5'd29; #1;
    vectors++;
    if (ReadData1 !== 32'h0000_0055) begin
      miscompares++;
      $display("FAIL no_bypass_in_reset got=%h exp=%h", ReadData1, 32'h0000_0055);
    end
    apply_edge();
    reset = 1'b0; RegWrite = 1'b0; #1;
    vectors++;
    if (ReadData1 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_priority got=%h exp=%h", ReadData1, 32'h0);
    end
    vectors++;
    if (ReadData2 !== SP_VAL) begin
      miscompares++;
      $display("FAIL reset_sp_reinit got=%h exp=%h", ReadData2, SP_VAL);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] exp_pre;
    write_reg(5'd11, 32'h1);
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h2;
`else
    exp_pre = 32'h1;
`endif
    reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd11; WriteData = 32'h2;
    ReadRegister1 = 5'd11; ReadRegister2 = 5'd11; #1;
    vectors++;
    if (ReadData1 !== exp_pre) begin
      miscompares++;
      $display("FAIL rdw_before_edge_rd1 got=%h exp=%h", ReadData1, exp_pre);
    end
    vectors++;
    if (ReadData2 !== exp_pre) begin
      miscompares++;
      $display("FAIL rdw_before_edge_rd2 got=%h exp=%h", ReadData2, exp_pre);
    end
    apply_edge();
    RegWrite = 1'b0; #1;
    vectors++;
    if (ReadData1 !== 32'h2) begin
      miscompares++;
      $display("FAIL rdw_after_edge got=%h exp=%h", ReadData1, 32'h2);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp1;
    logic [31:0] exp2;
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 39) == 0);
      RegWrite      = 1'($urandom_range(0, 1));
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData     = $urandom;
      ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 3) == 0) ? ReadRegister1 : 5'($urandom_range(0, 31));
      #1;
      exp1 = model_read_now(ReadRegister1);
      exp2 = model_read_now(ReadRegister2);
      vectors++;
      if (ReadData1 !== exp1) begin
        miscompares++;
        $display("FAIL random_rd1 iter=%0d idx=%0d got=%h exp=%h", n, ReadRegister1, ReadData1, exp1);
      end
      vectors++;
      if (ReadData2 !== exp2) begin
        miscompares++;
        $display("FAIL random_rd2 iter=%0d idx=%0d got=%h exp=%h", n, ReadRegister2, ReadData2, exp2);
      end
      apply_edge();
    end
    reset = 1'b0; RegWrite = 1'b0;
    // Final sweep of all stored state after the random phase.
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i); #1;
      exp1 = model_read(5'(i));
      vectors++;
      if (ReadData1 !== exp1) begin
        miscompares++;
        $display("FAIL final_sweep idx=%0d got=%h exp=%h", i, ReadData1, exp1);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    #2;
    test_reset();
    test_write_read();
    test_zero_guard();
    test_write_disabled();
    test_reset_priority();
    test_read_during_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32 x 32-bit MIPS general-purpose register file.
- Sits directly upstream of the ALU:
  - Read port 1 drives ALU operand A.
  - Read port 2 drives ALU operand B, or the immediate mux input.
- Sits directly downstream of the ALU: ALUResult, or memory data, returns through WriteData on the write-back path.
- Two asynchronous read ports and one synchronous write port; $zero is hardwired to 0.

Parameters:
- N_BITS, 32, register data width.
- SP_INIT, 32'h7FFF_EFFC, value loaded into register 29 ($sp) on reset.
- GP_INIT, 32'h1000_8000, value loaded into register 28 ($gp) on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  5  destination register index.
- WriteData  input  N_BITS  data to write (ALUResult or load data).
- ReadRegister1  input  5  source index for port 1 (rs).
- ReadRegister2  input  5  source index for port 2 (rt).
- ReadData1  output  N_BITS  contents of ReadRegister1; feeds ALU A.
- ReadData2  output  N_BITS  contents of ReadRegister2; feeds ALU B / store data.

Behaviour:
- Storage: 31 physical registers, indices 1..31. Index 0 has no storage and always reads 32'h0.
- Reset:
  - Synchronous; takes effect at the rising edge while reset=1.
  - All registers load 0, except reg 28 = GP_INIT and reg 29 = SP_INIT.
  - Reset has priority: a write presented in the same cycle as reset is discarded.
  - After reset the outputs follow the read indices: 0 for most indices, GP_INIT or SP_INIT for 28 and 29.
  - Before the first reset edge, register contents are undefined. The bench must not check them.
- Reset mid-operation: any pending write in that cycle is dropped. Stored values are reinitialised at that edge.
- Write:
  - When RegWrite=1 and reset=0, at the rising edge reg[WriteRegister] <= WriteData.
  - Writes to index 0 are ignored; no state change.
  - When RegWrite=0, no register changes, whatever the values of WriteRegister and WriteData.
- Read:
  - Purely combinational from stored state; zero-cycle latency from index change to data.
  - Both ports may address the same register; both return the same value.
- Read-during-write, same index, without the optional feature:
  - Port returns the old value during the write cycle.
  - Port returns the new value from the cycle after the edge.
- Width: WriteData is stored unmodified. No sign or zero extension happens inside the block.
- No X propagation: every index 0..31 yields a defined value after reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through bypass on each read port, applied when RegWrite=1, reset=0, WriteRegister!=0 and WriteRegister==ReadRegisterN.
  - In that case ReadDataN = WriteData combinationally, in the same cycle.
  - This supports write-back and decode in one cycle for the pipelined datapath.
  - Index 0 still reads 0.
  - No bypass while reset=1.
- Not defined: no bypass path. Read-during-write returns the old value, as stated in Behaviour.

Test Plan:
- Reset check: assert reset for one edge, then sweep ReadRegister1 over 0..31 -> 0 everywhere except 28 = 32'h1000_8000 and 29 = 32'h7FFF_EFFC.
- Write/read both ports: write 32'hDEAD_BEEF to reg 8 and 32'h0000_0005 to reg 9 on successive edges; read rs=8, rt=9 -> ReadData1 = 32'hDEAD_BEEF, ReadData2 = 32'h0000_0005.
- $zero guard: RegWrite=1, WriteRegister=0, WriteData=32'hFFFF_FFFF, one edge; read index 0 on both ports -> 32'h0.
- Write disabled: RegWrite=0, WriteRegister=8, WriteData=32'h1234_5678, one edge -> reg 8 still reads 32'hDEAD_BEEF.
- Reset priority: reset=1 and RegWrite=1 to reg 10 with 32'hAAAA_AAAA in the same cycle -> reg 10 = 0 after the edge.
- Read-during-write on reg 11 (old 32'h1, new 32'h2), checked before the edge:
  - Without REGFILE_BYPASS_EN -> ReadData1 = 32'h1.
  - With REGFILE_BYPASS_EN -> ReadData1 = 32'h2.
  - Both builds -> 32'h2 after the edge.
